axi_aw_rr_scheduler: RTL and testbench

Write-address scheduler for one master (initiator-side) port of the AXI node. It picks one of N_TARG_PORT slave-side AW requesters round-robin and forwards that AW beat. On the same cycle it pushes the routing tag {BIN_ID, OH_ID} into the write-data allocator's ID FIFO, so W beats are later steered in AW order. It also caps the number of outstanding write bursts awaiting a B response.

---
 rtl/axi_node_pkg.sv | 31 +++
 rtl/axi_rr_prio_pick.sv | 44 ++++
 rtl/axi_aw_rr_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_axi_aw_rr_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_node_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : axi_node_pkg                                                 |
// | Description : Shared types and helpers for the AXI node write-address      |
// |               path: AW scheduler state encoding, one-hot conversion and   |
// |               the round-robin "next index" rotation.                       |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package axi_node_pkg;

  // Widest port count the helpers below are sized for.
  localparam int unsigned MAX_PORTS = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } aw_state_e;

  // One-hot of a binary index; callers truncate to their own port count.
  function automatic logic [MAX_PORTS-1:0] onehot_of(input int unsigned idx);
    return MAX_PORTS'(1) << idx;
  endfunction

  // Index following ptr in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_rr_prio_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_rr_prio_pick                                             |
// | Description : Combinational round-robin selector. Scans req starting at   |
// |               ptr+1 and wrapping; ptr itself has lowest priority.          |
// | Ports       : req     - request vector (N bits)                            |
// |               ptr     - index of the last winner                           |
// |               gnt_oh  - one-hot grant (zero when no request)               |
// |               gnt_bin - binary grant index (zero when no request)          |
// |               any     - at least one request present                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axi_rr_prio_pick
  import axi_node_pkg::*;
#(
  parameter int N     = 7,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] gnt_bin,
  output logic             any
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    gnt_oh  = '0;
    gnt_bin = '0;
    any     = 1'b0;
    idx     = IDX_W'(rr_next(32'(ptr), 32'(N)));
    // Walk the ring once; the first hit wins, later hits are masked by any.
    for (int k = 0; k < N; k++) begin
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_bin = idx;
        gnt_oh  = N'(onehot_of(32'(idx)));
      end
      idx = IDX_W'(rr_next(32'(idx), 32'(N)));
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_aw_rr_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_aw_rr_scheduler                                          |
// | Description : AW scheduler for one master port of the AXI node. Picks one |
// |               slave-side requester round-robin, forwards its AW beat,      |
// |               pushes {BIN_ID, OH_ID} into the write-data ID FIFO on the    |
// |               handshake, and caps outstanding bursts awaiting B.           |
// | Ports       : clk, rst_n       - clock, async active-low reset             |
// |               awvalid_i        - per-requester AW valid                    |
// |               aw_payload_i     - per-requester packed AW payload           |
// |               awready_o        - per-requester AW ready (one-hot or zero)  |
// |               awvalid_o        - AW valid toward master port               |
// |               aw_payload_o     - selected payload                          |
// |               awready_i        - master-port AW ready                      |
// |               push_ID_o, ID_o  - ID FIFO push strobe and routing tag       |
// |               grant_FIFO_ID_i  - ID FIFO not full                          |
// |               b_done_i         - one B handshake completed                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axi_aw_rr_scheduler
  import axi_node_pkg::*;
#(
  parameter int N_TARG_PORT     = 7,
  parameter int LOG_N_TARG      = $clog2(N_TARG_PORT),
  parameter int AW_PAYLOAD_W    = 64,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [N_TARG_PORT-1:0]                   awvalid_i,
  input  logic [N_TARG_PORT-1:0][AW_PAYLOAD_W-1:0] aw_payload_i,
  output logic [N_TARG_PORT-1:0]                   awready_o,
  output logic                                     awvalid_o,
  output logic [AW_PAYLOAD_W-1:0]                  aw_payload_o,
  input  logic                                     awready_i,
  output logic                                     push_ID_o,
  output logic [LOG_N_TARG+N_TARG_PORT-1:0]        ID_o,
  input  logic                                     grant_FIFO_ID_i,
  input  logic                                     b_done_i
);

  // A single-port node still needs a one-bit index to hold state.
  localparam int IDX_W = (LOG_N_TARG > 0) ? LOG_N_TARG : 1;

  aw_state_e          state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   held_idx_q, held_idx_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;

  logic [N_TARG_PORT-1:0]            pick_oh;
  logic [IDX_W-1:0]                  pick_bin;
  logic                              pick_any;
  logic                              eligible;
  logic [IDX_W-1:0]                  sel_idx;
  logic [N_TARG_PORT-1:0]            sel_oh;
  logic                              sel_valid;
  logic                              handshake;
  logic [LOG_N_TARG+N_TARG_PORT-1:0] id_sel;

  axi_rr_prio_pick #(
    .N     (N_TARG_PORT),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (awvalid_i),
    .ptr     (rr_ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_bin (pick_bin),
    .any     (pick_any)
  );

  // While waiting in HOLD the FIFO can only drain and the counter can only
  // fall, so eligibility is only needed to start a new beat from IDLE.
  assign eligible = grant_FIFO_ID_i && (out_cnt_q < CNT_W'(MAX_OUTSTANDING));

  // Source selection: live arbitration in IDLE, frozen winner in HOLD so the
  // master side sees a stable payload until it accepts.
  always_comb begin
    sel_idx   = held_idx_q;
    sel_oh    = N_TARG_PORT'(onehot_of(32'(held_idx_q)));
    sel_valid = awvalid_i[held_idx_q];
    if (state_q == IDLE) begin
      sel_idx   = pick_bin;
      sel_oh    = pick_oh;
      sel_valid = eligible && pick_any;
    end
  end

  assign handshake = sel_valid && awready_i;

  if (LOG_N_TARG > 0) begin : g_id_with_bin
    assign id_sel = {sel_idx[LOG_N_TARG-1:0], sel_oh};
  end else begin : g_id_oh_only
    assign id_sel = sel_oh;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= IDX_W'(N_TARG_PORT - 1);
      held_idx_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      held_idx_q <= held_idx_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    held_idx_d = held_idx_q;
    out_cnt_d  = out_cnt_q;

    case (state_q)
      IDLE: begin
        if (sel_valid && !awready_i) begin
          state_d    = HOLD;
          held_idx_d = pick_bin;
        end
      end
      HOLD: begin
        if (handshake) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (handshake) begin
      rr_ptr_d = sel_idx;
    end

    // Handshake and B completion in the same cycle cancel out. A stray
    // b_done_i at zero is dropped rather than wrapping the counter.
    case ({handshake, b_done_i})
      2'b10: out_cnt_d = out_cnt_q + 1'b1;
      2'b01: begin
        if (out_cnt_q != '0) begin
          out_cnt_d = out_cnt_q - 1'b1;
        end
      end
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // Outputs are gated by rst_n so they fall as soon as reset is asserted,
  // not at the next clock edge.
  always_comb begin
    awvalid_o    = 1'b0;
    awready_o    = '0;
    aw_payload_o = '0;
    ID_o         = '0;
    push_ID_o    = 1'b0;
    if (rst_n && sel_valid) begin
      awvalid_o    = 1'b1;
      aw_payload_o = aw_payload_i[sel_idx];
      ID_o         = id_sel;
      if (awready_i) begin
        awready_o = sel_oh;
        push_ID_o = 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  a_hold_valid_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == HOLD) |-> awvalid_i[held_idx_q])
    else $error("requester dropped awvalid while its AW beat was held");

  a_push_fifo_ready: assert property (@(posedge clk) disable iff (!rst_n)
    push_ID_o |-> grant_FIFO_ID_i)
    else $error("ID FIFO push while FIFO full");

  a_b_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    (b_done_i && !handshake) |-> (out_cnt_q != '0))
    else $error("B completion with no outstanding write burst");

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    out_cnt_q <= CNT_W'(MAX_OUTSTANDING))
    else $error("outstanding counter above its limit");
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_aw_rr_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axi_aw_rr_scheduler                                       |
// | Description : Directed self-checking bench for axi_aw_rr_scheduler.        |
// |               dut uses default parameters; dut_m2 has MAX_OUTSTANDING=2.   |
// | Ports       : none                                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_axi_aw_rr_scheduler;
  import axi_node_pkg::*;

  localparam int N  = 7;
  localparam int LW = 3;
  localparam int PW = 64;

  logic clk = 1'b0;
  logic rst_n;

  logic [N-1:0]         awvalid_i;
  logic [N-1:0][PW-1:0] aw_payload_i;
  logic [N-1:0]         awready_o;
  logic                 awvalid_o;
  logic [PW-1:0]        aw_payload_o;
  logic                 awready_i;
  logic                 push_ID_o;
  logic [LW+N-1:0]      ID_o;
  logic                 grant_FIFO_ID_i;
  logic                 b_done_i;

  logic [N-1:0]         awvalid2;
  logic [N-1:0]         awready_o2;
  logic                 awvalid_o2;
  logic [PW-1:0]        aw_payload_o2;
  logic                 awready2;
  logic                 push2;
  logic [LW+N-1:0]      id2;
  logic                 grant2;
  logic                 b_done2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_aw_rr_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .awvalid_i       (awvalid_i),
    .aw_payload_i    (aw_payload_i),
    .awready_o       (awready_o),
    .awvalid_o       (awvalid_o),
    .aw_payload_o    (aw_payload_o),
    .awready_i       (awready_i),
    .push_ID_o       (push_ID_o),
    .ID_o            (ID_o),
    .grant_FIFO_ID_i (grant_FIFO_ID_i),
    .b_done_i        (b_done_i)
  );

  axi_aw_rr_scheduler #(.MAX_OUTSTANDING(2)) dut_m2 (
    .clk             (clk),
    .rst_n           (rst_n),
    .awvalid_i       (awvalid2),
    .aw_payload_i    (aw_payload_i),
    .awready_o       (awready_o2),
    .awvalid_o       (awvalid_o2),
    .aw_payload_o    (aw_payload_o2),
    .awready_i       (awready2),
    .push_ID_o       (push2),
    .ID_o            (id2),
    .grant_FIFO_ID_i (grant2),
    .b_done_i        (b_done2)
  );

  function automatic logic [PW-1:0] pl(input int p);
    return 64'hC0DE_0000_0000_0000 | 64'(p);
  endfunction

  function automatic logic [LW+N-1:0] exp_id(input int p);
    return {LW'(p), N'(1 << p)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    awvalid_i = '0; awready_i = 1'b0; grant_FIFO_ID_i = 1'b1; b_done_i = 1'b0;
    awvalid2  = '0; awready2  = 1'b0; grant2 = 1'b1;          b_done2  = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    awvalid_i = '1; awready_i = 1'b1; grant_FIFO_ID_i = 1'b1; b_done_i = 1'b0;
    awvalid2  = '0; awready2  = 1'b0; grant2 = 1'b1;          b_done2  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (awvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_awvalid: got %b want 0", awvalid_o); end
    n_tests++; if (awready_o !== 7'b0) begin n_fail++; $display("FAIL reset_awready: got %b want 0", awready_o); end
    n_tests++; if (push_ID_o !== 1'b0) begin n_fail++; $display("FAIL reset_push: got %b want 0", push_ID_o); end
    n_tests++; if (ID_o !== 10'b0) begin n_fail++; $display("FAIL reset_id: got %h want 0", ID_o); end
    n_tests++; if (dut.out_cnt_q !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", dut.out_cnt_q); end
    n_tests++; if (dut.rr_ptr_q !== 3'd6) begin n_fail++; $display("FAIL reset_ptr: got %0d want 6", dut.rr_ptr_q); end
    n_tests++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
    awvalid_i = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_two_ports();
    do_reset();
    awvalid_i = 7'b0000101; awready_i = 1'b1;
    @(negedge clk);
    n_tests++; if (push_ID_o !== 1'b1) begin n_fail++; $display("FAIL two_push0: got %b want 1", push_ID_o); end
    n_tests++; if (ID_o !== 10'b000_0000001) begin n_fail++; $display("FAIL two_id0: got %b want 0000000001", ID_o); end
    n_tests++; if (awready_o !== 7'b0000001) begin n_fail++; $display("FAIL two_rdy0: got %b want 0000001", awready_o); end
    n_tests++; if (aw_payload_o !== pl(0)) begin n_fail++; $display("FAIL two_pl0: got %h want %h", aw_payload_o, pl(0)); end
    tick();
    @(negedge clk);
    n_tests++; if (push_ID_o !== 1'b1) begin n_fail++; $display("FAIL two_push1: got %b want 1", push_ID_o); end
    n_tests++; if (ID_o !== 10'b010_0000100) begin n_fail++; $display("FAIL two_id1: got %b want 0100000100", ID_o); end
    tick();
    awvalid_i = '0;
  endtask

  task automatic test_rr_all();
    int order[8] = '{0, 1, 2, 3, 4, 5, 6, 0};
    int cnt[N];
    for (int p = 0; p < N; p++) cnt[p] = 0;
    do_reset();
    awvalid_i = '1; awready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_tests++;
      if (push_ID_o !== 1'b1 || ID_o !== exp_id(order[c])) begin
        n_fail++; $display("FAIL rr_order[%0d]: got push=%b id=%b want push=1 id=%b", c, push_ID_o, ID_o, exp_id(order[c]));
      end
      if (c < 7) begin
        for (int p = 0; p < N; p++) if (push_ID_o && awready_o == N'(1 << p)) cnt[p]++;
      end
      tick();
    end
    for (int p = 0; p < N; p++) begin
      n_tests++; if (cnt[p] !== 1) begin n_fail++; $display("FAIL rr_fair[%0d]: got %0d pushes want 1", p, cnt[p]); end
    end
    @(negedge clk);
    n_tests++; if (awvalid_o !== 1'b0) begin n_fail++; $display("FAIL rr_cap_valid: got %b want 0", awvalid_o); end
    n_tests++; if (dut.out_cnt_q !== 4'd8) begin n_fail++; $display("FAIL rr_cap_cnt: got %0d want 8", dut.out_cnt_q); end
    tick();
    awvalid_i = '0;
  endtask

  task automatic test_hold();
    do_reset();
    awvalid_i = 7'b0001000; awready_i = 1'b0;
    @(negedge clk);
    n_tests++; if (awvalid_o !== 1'b1 || push_ID_o !== 1'b0 || awready_o !== 7'b0) begin
      n_fail++; $display("FAIL hold_first: got v=%b push=%b rdy=%b want 1 0 0000000", awvalid_o, push_ID_o, awready_o);
    end
    tick();
    awvalid_i = 7'b0001010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++; if (dut.state_q !== HOLD) begin n_fail++; $display("FAIL hold_state[%0d]: got %0d want HOLD", c, dut.state_q); end
      n_tests++; if (aw_payload_o !== pl(3) || ID_o !== 10'b011_0001000) begin
        n_fail++; $display("FAIL hold_stable[%0d]: got pl=%h id=%b want %h 0110001000", c, aw_payload_o, ID_o, pl(3));
      end
      tick();
    end
    awready_i = 1'b1;
    @(negedge clk);
    n_tests++; if (push_ID_o !== 1'b1 || ID_o !== 10'b011_0001000 || awready_o !== 7'b0001000) begin
      n_fail++; $display("FAIL hold_release: got push=%b id=%b rdy=%b want 1 0110001000 0001000", push_ID_o, ID_o, awready_o);
    end
    tick();
    @(negedge clk);
    n_tests++; if (ID_o !== 10'b001_0000010) begin n_fail++; $display("FAIL hold_next: got %b want 0010000010", ID_o); end
    tick();
    awvalid_i = '0;
  endtask

  task automatic test_fifo_full();
    do_reset();
    awvalid_i = 7'b0000110; awready_i = 1'b1;
    @(negedge clk);
    n_tests++; if (ID_o !== 10'b001_0000010) begin n_fail++; $display("FAIL fifo_first: got %b want 0010000010", ID_o); end
    tick();
    grant_FIFO_ID_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++; if (awvalid_o !== 1'b0 || push_ID_o !== 1'b0 || awready_o !== 7'b0) begin
        n_fail++; $display("FAIL fifo_block[%0d]: got v=%b push=%b rdy=%b want 0 0 0000000", c, awvalid_o, push_ID_o, awready_o);
      end
      tick();
    end
    grant_FIFO_ID_i = 1'b1;
    @(negedge clk);
    n_tests++; if (ID_o !== 10'b010_0000100 || push_ID_o !== 1'b1) begin
      n_fail++; $display("FAIL fifo_resume: got id=%b push=%b want 0100000100 1", ID_o, push_ID_o);
    end
    tick();
    @(negedge clk);
    n_tests++; if (ID_o !== 10'b001_0000010) begin n_fail++; $display("FAIL fifo_wrap: got %b want 0010000010", ID_o); end
    tick();
    awvalid_i = '0;
  endtask

  task automatic test_max_outstanding();
    do_reset();
    awvalid2 = 7'b0000001; awready2 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++; if (push2 !== 1'b1) begin n_fail++; $display("FAIL max2_push[%0d]: got %b want 1", c, push2); end
      tick();
    end
    b_done2 = 1'b1;
    @(negedge clk);
    n_tests++; if (awvalid_o2 !== 1'b0 || awready_o2 !== 7'b0) begin
      n_fail++; $display("FAIL max2_capped: got v=%b rdy=%b want 0 0000000", awvalid_o2, awready_o2);
    end
    tick();
    b_done2 = 1'b0;
    @(negedge clk);
    n_tests++; if (awvalid_o2 !== 1'b1) begin n_fail++; $display("FAIL max2_resume: got %b want 1", awvalid_o2); end
    tick();
    awvalid2 = '0;
  endtask

  task automatic test_simul_bdone();
    do_reset();
    awvalid2 = 7'b0000001; awready2 = 1'b1;
    tick();
    awvalid2 = '0;
    n_tests++; if (dut_m2.out_cnt_q !== 2'd1) begin n_fail++; $display("FAIL simul_pre: got %0d want 1", dut_m2.out_cnt_q); end
    awvalid2 = 7'b0000001; b_done2 = 1'b1;
    @(negedge clk);
    n_tests++; if (push2 !== 1'b1) begin n_fail++; $display("FAIL simul_push: got %b want 1", push2); end
    tick();
    awvalid2 = '0; b_done2 = 1'b0;
    n_tests++; if (dut_m2.out_cnt_q !== 2'd1) begin n_fail++; $display("FAIL simul_cnt: got %0d want 1", dut_m2.out_cnt_q); end
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    awvalid_i = 7'b0000001; awready_i = 1'b1;
    tick();
    awvalid_i = 7'b0010000; awready_i = 1'b0;
    @(negedge clk);
    n_tests++; if (ID_o !== 10'b100_0010000) begin n_fail++; $display("FAIL rsthold_pick: got %b want 1000010000", ID_o); end
    tick();
    n_tests++; if (dut.state_q !== HOLD || dut.out_cnt_q !== 4'd1) begin
      n_fail++; $display("FAIL rsthold_pre: got state=%0d cnt=%0d want HOLD 1", dut.state_q, dut.out_cnt_q);
    end
    #2;
    awready_i = 1'b1;
    rst_n = 1'b0;
    #1;
    n_tests++; if (awvalid_o !== 1'b0 || push_ID_o !== 1'b0 || awready_o !== 7'b0) begin
      n_fail++; $display("FAIL rsthold_out: got v=%b push=%b rdy=%b want 0 0 0000000", awvalid_o, push_ID_o, awready_o);
    end
    n_tests++; if (dut.out_cnt_q !== 4'd0 || dut.state_q !== IDLE) begin
      n_fail++; $display("FAIL rsthold_regs: got cnt=%0d state=%0d want 0 IDLE", dut.out_cnt_q, dut.state_q);
    end
    awvalid_i = '0; awready_i = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) aw_payload_i[i] = pl(i);
    test_reset();
    test_two_ports();
    test_rr_all();
    test_hold();
    test_fifo_full();
    test_max_outstanding();
    test_simul_bdone();
    test_reset_in_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
